pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP_PERIODS, default 4, meaning PWM periods (of 100 clk each) between ramp steps; legal range 1..255.
REQ-002 SHALL have parameter STEP, default 1, meaning duty change per ramp step in percent; legal range 1..100.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tgt_valid  input  1  new target duty offered.
REQ-006 SHALL have port tgt_duty  input  7  requested target duty, percent.
REQ-007 SHALL have port tgt_ready  output  1  controller accepts target this cycle.
REQ-008 SHALL have port enable  input  1  ramp stepping allowed.
REQ-009 SHALL have port estop  input  1  emergency stop, forces duty 0.
REQ-010 SHALL have port duty_cycle  output  7  current duty value driven to the PWM.
REQ-011 SHALL have port duty_cycle_in  output  1  one-cycle load strobe to the PWM.
REQ-012 SHALL have port period_tick  output  1  high in last cycle of each 100-cycle period.
REQ-013 SHALL have port busy  output  1  high while duty_cycle differs from target or in HALT.

Function
REQ-014 SHALL keep a period counter pcnt counting 1..100, incrementing every cycle, wrapping 100->1, aligned with the PWM count sequence.
REQ-015 SHALL assert period_tick combinationally when pcnt==100.
REQ-016 SHALL implement states IDLE (duty==target), RAMP (stepping toward target), HALT (estop).
REQ-017 SHALL drive tgt_ready=1 in IDLE and RAMP, 0 in HALT and while estop is high; accept = tgt_valid & tgt_ready.
REQ-018 SHALL clamp accepted tgt_duty >100 to 100 before storing in the target register.
REQ-019 SHALL, on accept in IDLE with clamped target != duty_cycle, go to RAMP next cycle and clear the step-period counter scnt to 0; accept with target == duty_cycle leaves IDLE with no strobe.
REQ-020 SHALL, on accept in RAMP, replace the target without clearing scnt; the ramp continues toward the new target.
REQ-021 SHALL, in RAMP, increment scnt on each period_tick when enable=1 and step when period_tick & enable & scnt==STEP_PERIODS-1, then clear scnt.
REQ-022 SHALL compute a step as: if |target-duty|<=STEP then duty=target, else duty=duty+STEP or duty-STEP toward target; duty_cycle never leaves 0..100.
REQ-023 SHALL pulse duty_cycle_in for exactly one cycle, in the cycle after the step edge, with duty_cycle already holding the new value.
REQ-024 SHALL, on a step reaching target, return to IDLE in the same cycle the strobe is asserted.
REQ-025 SHALL, on a cycle where an accept coincides with a step, compute the step against the old target; the new target applies from the next step.
REQ-026 SHALL, with enable=0, freeze scnt and duty_cycle; pcnt, period_tick and target acceptance continue.
REQ-027 SHALL give estop priority over all other events: next cycle duty_cycle=0, duty_cycle_in pulsed one cycle (no period alignment), target=0, scnt=0, state HALT; a strobe SHALL NOT be issued if duty_cycle was already 0.
REQ-028 SHALL leave HALT to IDLE on the first cycle after estop samples low; duty_cycle stays 0.
REQ-029 SHALL assert busy in RAMP and HALT, deassert in IDLE.

Reset
REQ-030 SHALL, with rst high at a clock edge, set pcnt=1, scnt=0, target=0, duty_cycle=0, duty_cycle_in=0, state IDLE; so tgt_ready=1, busy=0, period_tick=0.
REQ-031 SHALL give rst priority over estop and accept; rst mid-ramp aborts the ramp with no strobe issued.
REQ-032 SHALL produce the first period_tick 99 cycles after the first edge with rst low.

Verification (STEP_PERIODS=2, STEP=5)
REQ-033 SHALL cover reset: rst held 3 cycles, released -> duty_cycle=0, tgt_ready=1, busy=0, period_tick on 99th cycle after release, repeating every 100.
REQ-034 SHALL cover ramp up: accept 20 in IDLE -> strobes after 2nd/4th/6th/8th ticks carrying 5/10/15/20, busy low with last strobe.
REQ-035 SHALL cover partial step and clamp: from 20 accept 23 -> single step to 23; then accept 120 -> stored 100, ramp ends at exactly 100.
REQ-036 SHALL cover retarget: ramp 0->50, at duty 15 accept 5 on a step cycle -> next value 20 (old target), then 15, 10, 5, then IDLE.
REQ-037 SHALL cover estop: mid-ramp at 30 assert estop -> next cycle duty_cycle=0 with strobe, tgt_ready=0, busy=1; release -> IDLE, duty 0, tgt_ready=1.
REQ-038 SHALL cover enable: enable=0 during ramp at 10 for 5 periods -> no strobes, duty stays 10; re-enable -> stepping resumes from preserved scnt.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller for a 100-step PWM: accepts target duties and
// walks duty_cycle toward them one step per STEP_PERIODS periods, with emergency stop.
module pwm_ramp_ctrl #(
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned STEP         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    input  logic [6:0] tgt_duty,
    output logic       tgt_ready,
    input  logic       enable,
    input  logic       estop,
    output logic [6:0] duty_cycle,
    output logic       duty_cycle_in,
    output logic       period_tick,
    output logic       busy
);

    localparam logic [6:0] PCNT_MAX  = 7'd100;
    localparam logic [6:0] DUTY_MAX  = 7'd100;
    localparam logic [6:0] STEP_D    = 7'(STEP);
    localparam logic [7:0] SCNT_LAST = 8'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t     state;
    logic [6:0] pcnt;
    logic [7:0] scnt;
    logic [6:0] target;
    logic [6:0] tgt_clamped;
    logic [6:0] next_target;
    logic [6:0] step_duty;
    logic [6:0] diff;
    logic       accept;
    logic       step_now;

    assign period_tick = (pcnt == PCNT_MAX);
    assign tgt_ready   = (state != HALT) && !estop;
    assign accept      = tgt_valid && tgt_ready;
    assign tgt_clamped = (tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt_duty;
    assign next_target = accept ? tgt_clamped : target;
    assign step_now    = (state == RAMP) && period_tick && enable && (scnt == SCNT_LAST);
    assign busy        = (state != IDLE);

    // Step is always taken against the currently stored target; a target
    // accepted in the same cycle only matters from the next step on.
    always_comb begin
        diff      = 7'd0;
        step_duty = duty_cycle;
        if (target >= duty_cycle) begin
            diff      = target - duty_cycle;
            step_duty = (diff <= STEP_D) ? target : duty_cycle + STEP_D;
        end else begin
            diff      = duty_cycle - target;
            step_duty = (diff <= STEP_D) ? target : duty_cycle - STEP_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt          <= 7'd1;
            scnt          <= 8'd0;
            target        <= 7'd0;
            duty_cycle    <= 7'd0;
            duty_cycle_in <= 1'b0;
            state         <= IDLE;
        end else begin
            pcnt          <= period_tick ? 7'd1 : pcnt + 7'd1;
            duty_cycle_in <= 1'b0;
            if (estop) begin
                duty_cycle    <= 7'd0;
                duty_cycle_in <= (duty_cycle != 7'd0);
                target        <= 7'd0;
                scnt          <= 8'd0;
                state         <= HALT;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            target <= tgt_clamped;
                            if (tgt_clamped != duty_cycle) begin
                                state <= RAMP;
                                scnt  <= 8'd0;
                            end
                        end
                    end
                    RAMP: begin
                        target <= next_target;
                        if (step_now) begin
                            duty_cycle    <= step_duty;
                            duty_cycle_in <= 1'b1;
                            scnt          <= 8'd0;
                            if (step_duty == next_target) state <= IDLE;
                        end else begin
                            if (period_tick && enable) scnt <= scnt + 8'd1;
                            // retarget onto the value already driven: nothing left to do
                            if (accept && (tgt_clamped == duty_cycle)) state <= IDLE;
                        end
                    end
                    HALT:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl (STEP_PERIODS=2, STEP=5): per-cycle comparison
// against an arithmetic model plus directed scenarios with literal strobe lists.
module tb_pwm_ramp_ctrl;

    localparam int SP = 2;
    localparam int ST = 5;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tgt_valid = 1'b0;
    logic [6:0] tgt_duty = 7'd0;
    logic       tgt_ready;
    logic       enable = 1'b1;
    logic       estop = 1'b0;
    logic [6:0] duty_cycle;
    logic       duty_cycle_in;
    logic       period_tick;
    logic       busy;

    int total = 0;
    int bad   = 0;

    pwm_ramp_ctrl #(.STEP_PERIODS(SP), .STEP(ST)) dut (
        .clk          (clk),
        .rst          (rst),
        .tgt_valid    (tgt_valid),
        .tgt_duty     (tgt_duty),
        .tgt_ready    (tgt_ready),
        .enable       (enable),
        .estop        (estop),
        .duty_cycle   (duty_cycle),
        .duty_cycle_in(duty_cycle_in),
        .period_tick  (period_tick),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Model: cycle index since reset gives the period phase; mode 0 idle, 1 ramp, 2 halt.
    int  m_k = 0, m_duty = 0, m_target = 0, m_scnt = 0, m_mode = 0;
    bit  m_strobe = 0, m_valid = 0;
    iq_t q_dut, q_mod;

    always @(posedge clk) begin
        if (rst) begin
            m_k = 0; m_duty = 0; m_target = 0; m_scnt = 0; m_mode = 0;
            m_strobe = 0; m_valid = 1;
        end else if (m_valid) begin
            int ct, nt, d, mv;
            bit tick, acc;
            tick = (m_k % 100) == 99;
            acc  = tgt_valid && (m_mode != 2) && !estop;
            ct   = (int'(tgt_duty) > 100) ? 100 : int'(tgt_duty);
            nt   = acc ? ct : m_target;
            m_strobe = 0;
            if (estop) begin
                m_strobe = (m_duty != 0);
                m_duty = 0; m_target = 0; m_scnt = 0; m_mode = 2;
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_target = nt;
                if (acc && ct != m_duty) begin
                    m_mode = 1; m_scnt = 0;
                end
            end else begin
                if (tick && enable) begin
                    m_scnt++;
                    if (m_scnt == SP) begin
                        d  = m_target - m_duty;
                        mv = (d < 0) ? -d : d;
                        if (mv > ST) mv = ST;
                        m_duty += (d < 0) ? -mv : mv;
                        m_scnt = 0;
                        m_strobe = 1;
                        if (m_duty == nt) m_mode = 0;
                    end
                end
                if (m_mode == 1 && !m_strobe && acc && ct == m_duty) m_mode = 0;
                m_target = nt;
            end
            m_k++;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("duty_cycle",    int'(duty_cycle),    m_duty);
            check("duty_cycle_in", int'(duty_cycle_in), int'(m_strobe));
            check("period_tick",   int'(period_tick),   int'((m_k % 100) == 99));
            check("busy",          int'(busy),          int'(m_mode != 0));
            check("tgt_ready",     int'(tgt_ready),     int'(m_mode != 2 && !estop));
            if (duty_cycle_in) q_dut.push_back(int'(duty_cycle));
            if (m_strobe) q_mod.push_back(m_duty);
        end
    end

    task automatic clear_q();
        q_dut.delete();
        q_mod.delete();
    endtask

    task automatic accept(input int v);
        tgt_valid = 1'b1;
        tgt_duty  = 7'(v);
        @(posedge clk); #1;
        tgt_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string nm);
        int c = 0;
        while (q_dut.size() < n && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        if (q_dut.size() < n) check({nm, "_timeout"}, q_dut.size(), n);
    endtask

    task automatic wait_ticks(input int n, input int budget, input string nm);
        int c = 0, t = 0;
        while (t < n && c < budget) begin
            @(negedge clk); #1;
            c++;
            if (period_tick) t++;
        end
        if (t < n) check({nm, "_timeout"}, t, n);
    endtask

    task automatic check_q(input string nm, input iq_t exp);
        check({nm, "_dut_count"}, q_dut.size(), exp.size());
        check({nm, "_mod_count"}, q_mod.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q_dut.size()) check({nm, "_dut_val"}, q_dut[i], exp[i]);
            if (i < q_mod.size()) check({nm, "_mod_val"}, q_mod[i], exp[i]);
        end
    endtask

    initial begin
        int  n;
        iq_t e;

        // reset: held 3 cycles, then first tick 99 edges later, then every 100
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_duty", int'(duty_cycle), 0);
        check("rst_ready", int'(tgt_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(period_tick), 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!period_tick && n < 150);
        check("first_tick_edge", n, 99);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!period_tick && n < 150);
        check("tick_period", n, 100);

        // ramp up 0 -> 20
        clear_q();
        accept(20);
        wait_strobes(4, 1000, "ramp_up");
        check("ramp_up_busy_last", int'(busy), 0);
        e = '{5, 10, 15, 20};
        check_q("ramp_up", e);

        // partial step, then equal target leaves controller idle
        clear_q();
        accept(23);
        wait_strobes(1, 400, "partial");
        e = '{23};
        check_q("partial", e);
        clear_q();
        accept(23);
        repeat (3) @(posedge clk); #1;
        check("equal_tgt_busy", int'(busy), 0);
        check("equal_tgt_strobes", q_dut.size(), 0);

        // clamp 120 -> 100
        clear_q();
        accept(120);
        wait_strobes(16, 3600, "clamp");
        e = {};
        for (int v = 28; v < 100; v += 5) e.push_back(v);
        e.push_back(100);
        check_q("clamp", e);
        check("clamp_final", int'(duty_cycle), 100);

        // estop from 100, then estop while already 0 gives no strobe
        clear_q();
        estop = 1'b1; #1;
        check("estop_ready_comb", int'(tgt_ready), 0);
        @(posedge clk); #1;
        check("estop_duty", int'(duty_cycle), 0);
        check("estop_strobe", int'(duty_cycle_in), 1);
        check("estop_busy", int'(busy), 1);
        repeat (3) @(posedge clk); #1;
        estop = 1'b0;
        @(posedge clk); #1;
        check("release_busy", int'(busy), 0);
        check("release_ready", int'(tgt_ready), 1);
        clear_q();
        estop = 1'b1;
        repeat (2) @(posedge clk); #1;
        estop = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("estop_at_zero_strobes", q_dut.size(), 0);

        // retarget on a step cycle: step uses old target 50
        clear_q();
        accept(50);
        wait_strobes(3, 800, "retarget_up");
        wait_ticks(2, 300, "retarget_tick");
        tgt_valid = 1'b1;
        tgt_duty  = 7'd5;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        wait_strobes(7, 1200, "retarget");
        check("retarget_busy", int'(busy), 0);
        e = '{5, 10, 15, 20, 15, 10, 5};
        check_q("retarget", e);

        // estop mid-ramp at 30
        clear_q();
        accept(60);
        wait_strobes(5, 1200, "to30");
        estop = 1'b1;
        @(posedge clk); #1;
        check("estop30_duty", int'(duty_cycle), 0);
        check("estop30_strobe", int'(duty_cycle_in), 1);
        check("estop30_ready", int'(tgt_ready), 0);
        check("estop30_busy", int'(busy), 1);
        estop = 1'b0;
        @(posedge clk); #1;
        check("estop30_rel_busy", int'(busy), 0);
        check("estop30_rel_ready", int'(tgt_ready), 1);
        check("estop30_rel_duty", int'(duty_cycle), 0);
        @(negedge clk); #1;
        e = '{10, 15, 20, 25, 30, 0};
        check_q("estop30", e);

        // enable freeze at 10 with scnt=1 preserved
        clear_q();
        accept(40);
        wait_strobes(2, 600, "to10");
        wait_ticks(1, 150, "en_tick");
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (500) @(posedge clk); #1;
        check("frozen_strobes", q_dut.size(), 2);
        check("frozen_duty", int'(duty_cycle), 10);
        enable = 1'b1;
        n = 0;
        for (int c = 0; c < 250 && q_dut.size() < 3; c++) begin
            @(negedge clk); #1;
            if (period_tick) n++;
        end
        check("resume_ticks", n, 1);
        e = '{5, 10, 15};
        check_q("enable", e);

        // reset mid-ramp aborts with no strobe and restarts period phase
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_duty", int'(duty_cycle), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_strobe", int'(duty_cycle_in), 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!period_tick && n < 150);
        check("midrst_tick_edge", n, 99);
        check("midrst_strobes", q_dut.size(), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
